usb_tx_serializer: RTL and testbench
====================================

USB_TX_SERIALIZER -- requirements
Module: usb_tx_serializer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, meaning clk cycles per USB bit time (48 MHz clk gives 12 Mb/s).
REQ-002 SHALL have port clk  in  1  clock.
REQ-003 SHALL have port n_rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port tx_start  in  1  request to begin a packet; honoured only in IDLE.
REQ-005 SHALL have port tx_data  in  8  next payload byte.
REQ-006 SHALL have port tx_data_valid  in  1  tx_data and tx_last are valid.
REQ-007 SHALL have port tx_last  in  1  the byte is the final byte of the packet.
REQ-008 SHALL have port tx_data_ready  out  1  one-cycle pulse when a byte is captured.
REQ-009 SHALL have port dp_out / dm_out  out  1 each  USB line drive.
REQ-010 SHALL have port tx_oe  out  1  line output enable.
REQ-011 SHALL have port tx_busy  out  1  high in every state except IDLE.
REQ-012 SHALL have port tx_done / tx_err  out  1 each  one-cycle pulses: packet end / underrun.

Function
REQ-013 Bit timer SHALL count 0..CLKS_PER_BIT-1, cleared on leaving IDLE; bit strobe is asserted at the count value CLKS_PER_BIT-1, and the line changes only on the cycle after a strobe.
REQ-014 FSM states SHALL be IDLE, SYNC, DATA, EOP_SE0, EOP_J.
REQ-015 IDLE behaviour:
  - Outputs: J (dp=1, dm=0), tx_oe=0.
  - tx_start=1 SHALL move to SYNC at the next edge; tx_oe=1 from that cycle.
  - tx_start outside IDLE SHALL be ignored.
REQ-016 SYNC SHALL send 8'h80 LSB-first (seven 0s, then a 1), then enter DATA.
REQ-017 NRZI: a 0 bit SHALL toggle the line between J and K (dp=0, dm=1); a 1 bit SHALL hold the line. The line starts from J.
REQ-018 Byte capture:
  - Happens at the strobe that ends SYNC or the previous byte.
  - If tx_data_valid=1: capture tx_data and tx_last into the shift register and pulse tx_data_ready in the same cycle.
  - Bits are sent LSB first.
REQ-019 Underrun: if tx_data_valid=0 at a capture point and the previous byte had tx_last=0, the block SHALL pulse tx_err and enter EOP_SE0.
REQ-020 Ones counter:
  - Counts consecutive 1 bits sent, including the final SYNC bit.
  - Any 0 (data or stuffed) SHALL reset it.
REQ-021 Bit stuffing: after six consecutive 1s, one stuffed 0 bit time SHALL be inserted. The stuffed bit consumes no data bit. Stuffing SHALL occur even after the last bit of the last byte.
REQ-022 After the last bit (and any stuff bit) of a tx_last byte, the block SHALL enter EOP_SE0.
REQ-023 EOP_SE0 SHALL drive dp=0, dm=0 for 2 bit times, then go to EOP_J.
REQ-024 EOP_J SHALL drive J with tx_oe=1 for 1 bit time, then go to IDLE. On that transition the block SHALL pulse tx_done and drop tx_oe.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 On n_rst=0, at any time including mid-packet, the block SHALL immediately force:
  - dp_out=1, dm_out=0, tx_oe=0;
  - tx_data_ready=0, tx_busy=0, tx_done=0, tx_err=0;
  - state IDLE, bit timer 0, ones counter 0, shift register 0.

Structure
REQ-027 A shared package usb_tx_pkg SHALL hold:
  - the state enum;
  - SYNC_PATTERN=8'h80;
  - STUFF_LIMIT=6;
  - EOP_SE0_BITS=2.
REQ-028 NRZI encoding and bit stuffing SHALL be in sub-module usb_tx_nrzi. It takes a bit, a bit strobe and a bypass-for-SE0 input, and returns the line state plus a stall flag for stuff bits.

Verification
REQ-029 Single byte 0xA5 with tx_last=1 (CLKS_PER_BIT=4):
  - Line: SYNC = K J K J K J K K.
  - One tx_data_ready pulse.
  - SE0 for 8 cycles, then J for 4 cycles.
  - tx_done 76 cycles after tx_oe rises.
REQ-030 Single byte 0xFF with tx_last=1:
  - Stuffed 0 after data bit 5.
  - DATA phase lasts 9 bit times (36 cycles).
  - Ones counter ends at 3.
REQ-031 Bytes 0x00 then 0x01 (last), with valid held high: two tx_data_ready pulses 32 cycles apart, and no idle gap on the line.
REQ-032 Byte 0x12 with tx_last=0, then valid deasserted: tx_err pulse at the capture point, then SE0 for 2 bit times, J, tx_done.
REQ-033 n_rst asserted mid-DATA: dp=1, dm=0, tx_oe=0, tx_busy=0 in the same cycle. A new tx_start after reset sends a clean SYNC.
REQ-034 tx_start pulsed during DATA: no effect on line output or byte count.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared types and constants for the USB full-speed transmit path
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    DATA    = 3'd2,
    EOP_SE0 = 3'd3,
    EOP_J   = 3'd4
  } tx_state_e;

  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  localparam int         STUFF_LIMIT  = 6;
  localparam int         EOP_SE0_BITS = 2;

endpackage

// File: rtl/usb_tx_nrzi.sv
// rtl/usb_tx_nrzi.sv - NRZI line encoder with bit stuffing and SE0/J overrides
module usb_tx_nrzi
  import usb_tx_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic stb_i,    // load the next bit-time onto the line
  input  logic bit_i,    // data bit for that bit-time (ignored when stalling)
  input  logic se0_i,    // drive SE0 instead of a data bit
  input  logic idle_i,   // drive J and restart NRZI from J
  output logic dp_o,
  output logic dm_o,
  output logic stall_o   // the next bit-time is a stuffed 0, hold the data bit
);

  logic       level_q, level_d;  // 1 = J, 0 = K
  logic [2:0] ones_q, ones_d;
  logic       dp_q, dp_d, dm_q, dm_d;

  assign stall_o = (ones_q == 3'(STUFF_LIMIT));
  assign dp_o    = dp_q;
  assign dm_o    = dm_q;

  // Next line state: SE0/J overrides leave the ones run alone, stuffed or 0 bits toggle
  always_comb begin
    level_d = level_q;
    ones_d  = ones_q;
    dp_d    = dp_q;
    dm_d    = dm_q;
    if (stb_i) begin
      if (se0_i) begin
        level_d = 1'b1;
        dp_d    = 1'b0;
        dm_d    = 1'b0;
      end else if (idle_i) begin
        level_d = 1'b1;
        dp_d    = 1'b1;
        dm_d    = 1'b0;
      end else begin
        if (stall_o || !bit_i) begin
          level_d = ~level_q;
          ones_d  = 3'd0;
        end else begin
          ones_d  = ones_q + 3'd1;
        end
        dp_d = level_d;
        dm_d = ~level_d;
      end
    end
  end

  // Line and run-length registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      level_q <= 1'b1;
      ones_q  <= 3'd0;
      dp_q    <= 1'b1;
      dm_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      ones_q  <= ones_d;
      dp_q    <= dp_d;
      dm_q    <= dm_d;
    end
  end

endmodule

// File: rtl/usb_tx_serializer.sv
// rtl/usb_tx_serializer.sv - USB full-speed packet serializer: SYNC, payload bytes, EOP
module usb_tx_serializer
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  input  logic       tx_last,
  output logic       tx_data_ready,
  output logic       dp_out,
  output logic       dm_out,
  output logic       tx_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LAST_BIT = 3'd7;
  localparam logic [2:0]      SE0_LAST = 3'(EOP_SE0_BITS - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bitcnt_q, bitcnt_d;  // bit index in SYNC/DATA, bit-time count in EOP_SE0
  logic [7:0]       shift_q, shift_d;
  logic             last_q, last_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             oe_q, busy_q;

  logic             bit_stb;
  logic             stall;
  logic             byte_end;
  logic             can_capture;
  logic             nrzi_stb, nrzi_bit, nrzi_se0, nrzi_idle;

  assign bit_stb     = (state_q != IDLE) && (cnt_q == CNT_MAX);
  // A stuffed bit after bit 7 postpones the capture point by one bit-time
  assign byte_end    = bit_stb && !stall && (bitcnt_q == LAST_BIT);
  assign can_capture = tx_data_valid && !last_q;

  assign tx_data_ready = ready_q;
  assign tx_oe         = oe_q;
  assign tx_busy       = busy_q;
  assign tx_done       = done_q;
  assign tx_err        = err_q;

  usb_tx_nrzi u_nrzi (
    .clk     (clk),
    .n_rst   (n_rst),
    .stb_i   (nrzi_stb),
    .bit_i   (nrzi_bit),
    .se0_i   (nrzi_se0),
    .idle_i  (nrzi_idle),
    .dp_o    (dp_out),
    .dm_o    (dm_out),
    .stall_o (stall)
  );

  // Bit timer: held at 0 in IDLE so the first SYNC bit gets a full bit-time
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else if (state_q == IDLE || cnt_q == CNT_MAX) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      bitcnt_q <= 3'd0;
      shift_q  <= 8'd0;
      last_q   <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      last_q   <= last_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      done_q   <= done_d;
      oe_q     <= (state_d != IDLE);
      busy_q   <= (state_d != IDLE);
    end
  end

  // Next-state: transitions only on a bit strobe, except the start request
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (tx_start) state_d = SYNC;
      SYNC, DATA: if (byte_end) state_d = can_capture ? DATA : EOP_SE0;
      EOP_SE0:    if (bit_stb && bitcnt_q == SE0_LAST) state_d = EOP_J;
      EOP_J:      if (bit_stb) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Per-bit-time actions: choose what the encoder sends next, capture bytes, pulse flags
  always_comb begin
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    last_d    = last_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    done_d    = 1'b0;
    nrzi_stb  = 1'b0;
    nrzi_bit  = 1'b0;
    nrzi_se0  = 1'b0;
    nrzi_idle = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_start) begin
          nrzi_stb = 1'b1;
          nrzi_bit = SYNC_PATTERN[0];
          shift_d  = {1'b0, SYNC_PATTERN[7:1]};
          bitcnt_d = 3'd0;
          last_d   = 1'b0;
        end
      end
      SYNC, DATA: begin
        if (bit_stb) begin
          nrzi_stb = 1'b1;
          if (!stall) begin
            if (bitcnt_q != LAST_BIT) begin
              nrzi_bit = shift_q[0];
              shift_d  = {1'b0, shift_q[7:1]};
              bitcnt_d = bitcnt_q + 3'd1;
            end else if (can_capture) begin
              nrzi_bit = tx_data[0];
              shift_d  = {1'b0, tx_data[7:1]};
              last_d   = tx_last;
              bitcnt_d = 3'd0;
              ready_d  = 1'b1;
            end else begin
              nrzi_se0 = 1'b1;
              bitcnt_d = 3'd0;
              err_d    = !last_q;
            end
          end
        end
      end
      EOP_SE0: begin
        if (bit_stb) begin
          nrzi_stb = 1'b1;
          if (bitcnt_q == SE0_LAST) begin
            nrzi_idle = 1'b1;
            bitcnt_d  = 3'd0;
          end else begin
            nrzi_se0 = 1'b1;
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
      EOP_J: begin
        if (bit_stb) begin
          nrzi_stb  = 1'b1;
          nrzi_idle = 1'b1;
          done_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// tb/tb_usb_tx_serializer.sv - self-checking bench for usb_tx_serializer
module tb_usb_tx_serializer;

  localparam int         CPB = 4;
  localparam logic [1:0] LJ  = 2'b10;
  localparam logic [1:0] LK  = 2'b01;
  localparam logic [1:0] LS0 = 2'b00;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_data_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_data_ready, dp_out, dm_out, tx_oe, tx_busy, tx_done, tx_err;

  always #5 clk = ~clk;

  usb_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_last       (tx_last),
    .tx_data_ready (tx_data_ready),
    .dp_out        (dp_out),
    .dm_out        (dm_out),
    .tx_oe         (tx_oe),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .tx_err        (tx_err)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: expected line symbol per bit-time, plus event cycles
  logic [7:0] pkt[$];
  logic [1:0] m_slots[$];
  int         m_ready[$];
  int         m_err;
  int         m_done;
  bit         m_level;
  int         m_ones;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic m_send(input bit b);
    if (!b) begin
      m_level = ~m_level;
      m_ones  = 0;
    end else begin
      m_ones++;
    end
    m_slots.push_back(m_level ? LJ : LK);
    if (m_ones == 6) begin
      m_level = ~m_level;
      m_ones  = 0;
      m_slots.push_back(m_level ? LJ : LK);
    end
  endtask

  task automatic build_model(input bit final_last);
    logic [7:0] b;
    m_slots.delete();
    m_ready.delete();
    m_level = 1'b1;
    m_ones  = 0;
    m_err   = -1;
    b = 8'h80;
    for (int i = 0; i < 8; i++) m_send(b[i]);
    for (int j = 0; j < pkt.size(); j++) begin
      m_ready.push_back(m_slots.size() * CPB);
      b = pkt[j];
      for (int k = 0; k < 8; k++) m_send(b[k]);
    end
    if (!final_last) m_err = m_slots.size() * CPB;
    m_slots.push_back(LS0);
    m_slots.push_back(LS0);
    m_slots.push_back(LJ);
    m_done = m_slots.size() * CPB;
  endtask

  task automatic run_packet(input string name, input bit final_last, input int poke_at, input int rst_at);
    int src;
    int ri;
    logic [1:0] exp_line;
    bit exp_ready;
    build_model(final_last);
    @(negedge clk);
    src           = 0;
    ri            = 0;
    tx_data       = (pkt.size() > 0) ? pkt[0] : 8'd0;
    tx_last       = final_last && (pkt.size() == 1);
    tx_data_valid = (pkt.size() > 0);
    tx_start      = 1'b1;
    @(negedge clk);
    for (int t = 0; t <= m_done; t++) begin
      if (t > 0) @(negedge clk);
      tx_start = (t == poke_at);
      if (t == rst_at) begin
        n_rst = 1'b0;
        #1;
        check($sformatf("%s rst dp", name), 8'(dp_out), 8'd1);
        check($sformatf("%s rst dm", name), 8'(dm_out), 8'd0);
        check($sformatf("%s rst oe", name), 8'(tx_oe), 8'd0);
        check($sformatf("%s rst busy", name), 8'(tx_busy), 8'd0);
        check($sformatf("%s rst ready", name), 8'(tx_data_ready), 8'd0);
        @(negedge clk);
        n_rst         = 1'b1;
        tx_start      = 1'b0;
        tx_data_valid = 1'b0;
        return;
      end
      exp_line  = (t < m_done) ? m_slots[t / CPB] : LJ;
      exp_ready = (ri < m_ready.size()) && (m_ready[ri] == t);
      if (exp_ready) ri++;
      check($sformatf("%s line t=%0d", name, t), 8'({dp_out, dm_out}), 8'(exp_line));
      check($sformatf("%s oe t=%0d", name, t), 8'(tx_oe), 8'(t < m_done));
      check($sformatf("%s busy t=%0d", name, t), 8'(tx_busy), 8'(t < m_done));
      check($sformatf("%s ready t=%0d", name, t), 8'(tx_data_ready), 8'(exp_ready));
      check($sformatf("%s err t=%0d", name, t), 8'(tx_err), 8'(t == m_err));
      check($sformatf("%s done t=%0d", name, t), 8'(tx_done), 8'(t == m_done));
      if (tx_data_ready === 1'b1) begin
        src++;
        if (src < pkt.size()) begin
          tx_data = pkt[src];
          tx_last = final_last && (src == pkt.size() - 1);
        end else begin
          tx_data_valid = 1'b0;
        end
      end
    end
    tx_data_valid = 1'b0;
    tx_start      = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    #2 n_rst = 1'b0;
    #1;
    check("reset dp", 8'(dp_out), 8'd1);
    check("reset dm", 8'(dm_out), 8'd0);
    check("reset oe", 8'(tx_oe), 8'd0);
    check("reset busy", 8'(tx_busy), 8'd0);
    check("reset ready", 8'(tx_data_ready), 8'd0);
    check("reset done", 8'(tx_done), 8'd0);
    check("reset err", 8'(tx_err), 8'd0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle line", 8'({dp_out, dm_out}), 8'(LJ));
      check("idle oe", 8'(tx_oe), 8'd0);
    end

    pkt = '{8'hA5};             run_packet("a5", 1'b1, -1, -1);
    pkt = '{8'hFF};             run_packet("ff", 1'b1, -1, -1);
    pkt = '{8'h00, 8'h01};      run_packet("00_01", 1'b1, -1, -1);
    pkt = '{8'h12};             run_packet("underrun", 1'b0, -1, -1);
    pkt = '{8'hFC};             run_packet("stuff_tail", 1'b1, -1, -1);
    pkt = '{8'hFF, 8'hFF};      run_packet("ff_ff", 1'b1, -1, -1);
    pkt = '{8'h5A, 8'h33, 8'hC3}; run_packet("poke", 1'b1, 40, -1);
    pkt = '{8'h5A, 8'h33};      run_packet("midrst", 1'b1, -1, 45);
    pkt = '{8'hA5};             run_packet("after_rst", 1'b1, -1, -1);

    for (int p = 0; p < 8; p++) begin
      int n;
      pkt.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++)
        pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      run_packet($sformatf("rand%0d", p), ($urandom_range(0, 4) != 0), -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
